// File: rtl/rf_pkg.sv
// Shared definitions for the multi-ported architectural register file.
// Holds default sizing constants, storage typedefs and the clear/ready state enum.
package rf_pkg;

  localparam int unsigned RF_NUM_REGS      = 32;
  localparam int unsigned RF_DATA_LEN      = 32;
  localparam int unsigned RF_NUM_W_PORTS   = 4;
  localparam int unsigned RF_NUM_R_PORTS   = 6;
  localparam int unsigned RF_CLR_PER_CYCLE = 4;
  localparam int unsigned RF_ADDR_LEN      = $clog2(RF_NUM_REGS);

  typedef logic [RF_ADDR_LEN-1:0] rf_addr_t;
  typedef logic [RF_DATA_LEN-1:0] rf_data_t;

  // RF_CLEARING: sequencer zeroing the array; RF_READY: normal read/write service.
  typedef enum logic {
    RF_CLEARING = 1'b0,
    RF_READY    = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rf_wr_arbiter.sv
// Youngest-wins write conflict qualifier (combinational).
// A port commits when it is enabled, targets a nonzero address, and no younger
// (higher-index) enabled port targets the same address. At most one port commits
// per address, so the commit vector can also drive the bypass select.
//
// Ports:
//   w_en    in   NUM_PORTS             write enables, already gated by the caller
//   w_addr  in   NUM_PORTS x ADDR_LEN  write addresses
//   commit  out  NUM_PORTS             per-port commit enables
module rf_wr_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned NUM_PORTS = RF_NUM_W_PORTS,
  parameter int unsigned ADDR_LEN  = RF_ADDR_LEN
) (
  input  logic [NUM_PORTS-1:0]               w_en,
  input  logic [NUM_PORTS-1:0][ADDR_LEN-1:0] w_addr,
  output logic [NUM_PORTS-1:0]               commit
);

  always_comb begin
    commit = '0;
    for (int unsigned w = 0; w < NUM_PORTS; w++) begin
      commit[w] = w_en[w] && (w_addr[w] != '0);
      // Any younger port hitting the same address shadows this one.
      for (int unsigned y = w + 1; y < NUM_PORTS; y++) begin
        if (w_en[y] && (w_addr[y] == w_addr[w])) begin
          commit[w] = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-ported architectural register file.
// Retire-side write ports with youngest-wins conflict resolution, issue-side
// registered read ports with valid, and a multi-cycle clear sequencer that holds
// rf_rdy low while the array is zeroed CLR_PER_CYCLE registers per edge.
// Register 0 is hardwired to read zero. The storage array has no reset; the clear
// sequence that always follows reset initialises it.
//
// Optional feature (macro RF_BYPASS_EN): a read accepted on the same edge as a
// committing write to the same nonzero address returns the write data. Without
// the macro it returns the value held before the edge. Ports are identical.
//
// Ports:
//   clk      in   1                         rising-edge clock
//   rst      in   1                         asynchronous active-high reset
//   clr_req  in   1                         request full clear (pulse)
//   rf_rdy   out  1                         array initialised, reads/writes accepted
//   w_en     in   NUM_W_PORTS               write enables (higher index = younger)
//   w_addr   in   NUM_W_PORTS x REG_ADDR_LEN write addresses
//   w_data   in   NUM_W_PORTS x DATA_LEN     write data
//   r_en     in   NUM_R_PORTS               read enables
//   r_addr   in   NUM_R_PORTS x REG_ADDR_LEN read addresses
//   r_val    out  NUM_R_PORTS               read valid, one cycle after accepted r_en
//   r_data   out  NUM_R_PORTS x DATA_LEN     registered read data (0 when not valid)
module regfile_mp
  import rf_pkg::*;
#(
  parameter int unsigned NUM_REGS      = RF_NUM_REGS,       // power of 2, >= 2
  parameter int unsigned DATA_LEN      = RF_DATA_LEN,
  parameter int unsigned NUM_W_PORTS   = RF_NUM_W_PORTS,
  parameter int unsigned NUM_R_PORTS   = RF_NUM_R_PORTS,
  parameter int unsigned CLR_PER_CYCLE = RF_CLR_PER_CYCLE,  // must divide NUM_REGS
  localparam int unsigned REG_ADDR_LEN = $clog2(NUM_REGS)
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     clr_req,
  output logic                                     rf_rdy,
  input  logic [NUM_W_PORTS-1:0]                   w_en,
  input  logic [NUM_W_PORTS-1:0][REG_ADDR_LEN-1:0] w_addr,
  input  logic [NUM_W_PORTS-1:0][DATA_LEN-1:0]     w_data,
  input  logic [NUM_R_PORTS-1:0]                   r_en,
  input  logic [NUM_R_PORTS-1:0][REG_ADDR_LEN-1:0] r_addr,
  output logic [NUM_R_PORTS-1:0]                   r_val,
  output logic [NUM_R_PORTS-1:0][DATA_LEN-1:0]     r_data
);

  // ---------------------------------------------------------------------------
  // Clear sequencer FSM
  // ---------------------------------------------------------------------------
  rf_state_e               state_q, state_d;
  logic [REG_ADDR_LEN-1:0] clr_ptr_q, clr_ptr_d;
  logic                    clr_last;
  logic                    clr_step;
  logic                    wr_ok;
  logic                    rd_ok;

  assign clr_last = (clr_ptr_q == REG_ADDR_LEN'(NUM_REGS - CLR_PER_CYCLE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RF_CLEARING;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    unique case (state_q)
      RF_CLEARING: begin
        if (clr_req) begin
          // Restart from the bottom; nothing is cleared on this edge.
          clr_ptr_d = '0;
        end else begin
          // Pointer wraps back to 0 after the final chunk.
          clr_ptr_d = clr_ptr_q + REG_ADDR_LEN'(CLR_PER_CYCLE);
          if (clr_last) begin
            state_d = RF_READY;
          end
        end
      end
      RF_READY: begin
        if (clr_req) begin
          state_d   = RF_CLEARING;
          clr_ptr_d = '0;
        end
      end
      default: begin
        state_d   = RF_CLEARING;
        clr_ptr_d = '0;
      end
    endcase
  end

  // rf_rdy comes straight from the state register, so it is glitch-free.
  always_comb begin
    rf_rdy   = (state_q == RF_READY);
    clr_step = (state_q == RF_CLEARING) && !clr_req;
    // Writes are dropped on the READY->CLEARING edge; reads still complete.
    wr_ok    = (state_q == RF_READY) && !clr_req;
    rd_ok    = (state_q == RF_READY);
  end

  // ---------------------------------------------------------------------------
  // Write arbitration
  // ---------------------------------------------------------------------------
  logic [NUM_W_PORTS-1:0] w_qual;
  logic [NUM_W_PORTS-1:0] w_commit;

  assign w_qual = w_en & {NUM_W_PORTS{wr_ok}};

  rf_wr_arbiter #(
    .NUM_PORTS (NUM_W_PORTS),
    .ADDR_LEN  (REG_ADDR_LEN)
  ) u_wr_arbiter (
    .w_en   (w_qual),
    .w_addr (w_addr),
    .commit (w_commit)
  );

  // ---------------------------------------------------------------------------
  // Storage (no reset; zeroed by the clear sequence)
  // ---------------------------------------------------------------------------
  logic [DATA_LEN-1:0] mem_q [NUM_REGS];

  always_ff @(posedge clk) begin
    if (clr_step) begin
      for (int unsigned i = 0; i < CLR_PER_CYCLE; i++) begin
        mem_q[clr_ptr_q + REG_ADDR_LEN'(i)] <= '0;
      end
    end
    // clr_step and any commit are mutually exclusive by construction.
    for (int unsigned w = 0; w < NUM_W_PORTS; w++) begin
      if (w_commit[w]) begin
        mem_q[w_addr[w]] <= w_data[w];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  logic [NUM_R_PORTS-1:0][DATA_LEN-1:0] rd_val;

  always_comb begin
    rd_val = '0;
    for (int unsigned r = 0; r < NUM_R_PORTS; r++) begin
      if (r_addr[r] != '0) begin
        rd_val[r] = mem_q[r_addr[r]];
      end
`ifdef RF_BYPASS_EN
      // w_commit is one-hot per address and never set for address 0.
      for (int unsigned w = 0; w < NUM_W_PORTS; w++) begin
        if (w_commit[w] && (w_addr[w] == r_addr[r])) begin
          rd_val[r] = w_data[w];
        end
      end
`endif
    end
  end

  logic [NUM_R_PORTS-1:0]               r_val_q;
  logic [NUM_R_PORTS-1:0][DATA_LEN-1:0] r_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_val_q  <= '0;
      r_data_q <= '0;
    end else begin
      for (int unsigned r = 0; r < NUM_R_PORTS; r++) begin
        if (r_en[r] && rd_ok) begin
          r_val_q[r]  <= 1'b1;
          r_data_q[r] <= rd_val[r];
        end else begin
          r_val_q[r]  <= 1'b0;
          r_data_q[r] <= '0;
        end
      end
    end
  end

  assign r_val  = r_val_q;
  assign r_data = r_data_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (default parameters).
// Every clock edge is mirrored by an array-based reference model; directed
// table vectors and hand sequences add constant expectations on top.
module tb_regfile_mp;

  localparam int NR  = 32;
  localparam int DL  = 32;
  localparam int NW  = 4;
  localparam int NRD = 6;
  localparam int CPC = 4;
  localparam int NCH = NR / CPC;
  localparam int AL  = 5;

  logic                    clk;
  logic                    rst;
  logic                    clr_req;
  logic                    rf_rdy;
  logic [NW-1:0]           w_en;
  logic [NW-1:0][AL-1:0]   w_addr;
  logic [NW-1:0][DL-1:0]   w_data;
  logic [NRD-1:0]          r_en;
  logic [NRD-1:0][AL-1:0]  r_addr;
  logic [NRD-1:0]          r_val;
  logic [NRD-1:0][DL-1:0]  r_data;

  regfile_mp dut (
    .clk     (clk),
    .rst     (rst),
    .clr_req (clr_req),
    .rf_rdy  (rf_rdy),
    .w_en    (w_en),
    .w_addr  (w_addr),
    .w_data  (w_data),
    .r_en    (r_en),
    .r_addr  (r_addr),
    .r_val   (r_val),
    .r_data  (r_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [DL-1:0]  mem_m [NR];
  int             clr_left;   // clear edges still owed before ready
  logic [NRD-1:0] ev;
  logic [DL-1:0]  ed [NRD];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    clr_req = 1'b0;
    w_en    = '0;
    w_addr  = '0;
    w_data  = '0;
    r_en    = '0;
    r_addr  = '0;
  endtask

  task automatic model_reset();
    clr_left = NCH;
    ev       = '0;
    for (int r = 0; r < NRD; r++) ed[r] = '0;
  endtask

  // One clock edge: update model from the inputs held across the edge, then
  // compare every output 1 time unit later.
  task automatic cycle();
    logic [DL-1:0] pre [NR];
    @(posedge clk);
    pre = mem_m;
    if (clr_left == 0) begin
      if (!clr_req) begin
        // Ascending order: the youngest writer lands last and wins.
        for (int w = 0; w < NW; w++)
          if (w_en[w] && w_addr[w] != 0) mem_m[w_addr[w]] = w_data[w];
      end
      for (int r = 0; r < NRD; r++) begin
        ev[r] = r_en[r];
        if (!r_en[r] || r_addr[r] == 0) ed[r] = '0;
        else begin
`ifdef RF_BYPASS_EN
          ed[r] = mem_m[r_addr[r]];
`else
          ed[r] = pre[r_addr[r]];
`endif
        end
      end
      if (clr_req) clr_left = NCH;
    end else begin
      ev = '0;
      for (int r = 0; r < NRD; r++) ed[r] = '0;
      if (clr_req) clr_left = NCH;
      else begin
        for (int i = 0; i < CPC; i++) mem_m[(NCH - clr_left) * CPC + i] = '0;
        clr_left--;
      end
    end
    #1;
    check("rf_rdy", 32'(rf_rdy), 32'(clr_left == 0));
    for (int r = 0; r < NRD; r++) begin
      check($sformatf("r_val[%0d]", r), 32'(r_val[r]), 32'(ev[r]));
      check($sformatf("r_data[%0d]", r), r_data[r], ed[r]);
    end
  endtask

  task automatic read_all_zero(input string tag);
    for (int b = 0; b < NR; b += NRD) begin
      idle();
      for (int r = 0; r < NRD; r++) begin
        r_en[r]   = 1'b1;
        r_addr[r] = AL'((b + r) % NR);
      end
      cycle();
      for (int r = 0; r < NRD; r++) begin
        check($sformatf("%s val x%0d", tag, (b + r) % NR), 32'(r_val[r]), 32'd1);
        check($sformatf("%s data x%0d", tag, (b + r) % NR), r_data[r], 32'd0);
      end
    end
  endtask

  typedef struct {
    int          port;
    int          addr;
    logic [31:0] data;
    logic [31:0] exp;
  } wr_vec_t;

  wr_vec_t vecs [6];

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] bp_exp;
    vecs[0] = '{0, 5,  32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1] = '{1, 0,  32'hFFFFFFFF, 32'h00000000};
    vecs[2] = '{2, 31, 32'hCAFEF00D, 32'hCAFEF00D};
    vecs[3] = '{3, 1,  32'h00000001, 32'h00000001};
    vecs[4] = '{0, 5,  32'h12345678, 32'h12345678};
    vecs[5] = '{3, 16, 32'hFFFFFFFF, 32'hFFFFFFFF};

    for (int i = 0; i < NR; i++) mem_m[i] = '0;
    idle();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset rf_rdy", 32'(rf_rdy), 32'd0);
    check("reset r_val", 32'(r_val), 32'd0);
    rst = 1'b0;

    // Clear after reset: ready after exactly the 8th edge.
    for (int e = 1; e <= NCH; e++) begin
      cycle();
      check($sformatf("init rdy edge %0d", e), 32'(rf_rdy), 32'(e == NCH));
    end
    read_all_zero("init");

    // Table: single write then read back.
    for (int i = 0; i < 6; i++) begin
      idle();
      w_en[vecs[i].port]   = 1'b1;
      w_addr[vecs[i].port] = AL'(vecs[i].addr);
      w_data[vecs[i].port] = vecs[i].data;
      cycle();
      idle();
      r_en[0]   = 1'b1;
      r_addr[0] = AL'(vecs[i].addr);
      cycle();
      check($sformatf("vec%0d r_val", i), 32'(r_val[0]), 32'd1);
      check($sformatf("vec%0d r_data", i), r_data[0], vecs[i].exp);
    end

    // Same-edge conflict: port 3 is younger than port 1.
    idle();
    w_en      = 4'b1010;
    w_addr[1] = 5'd7;  w_data[1] = 32'h11;
    w_addr[3] = 5'd7;  w_data[3] = 32'h33;
    cycle();
    idle();
    r_en[2] = 1'b1; r_addr[2] = 5'd7;
    cycle();
    check("conflict x7", r_data[2], 32'h33);

    // Same-edge write and read of x9.
    idle();
    w_en[0] = 1'b1; w_addr[0] = 5'd9; w_data[0] = 32'h1;
    cycle();
    idle();
    w_en[0] = 1'b1; w_addr[0] = 5'd9; w_data[0] = 32'h77;
    w_en[2] = 1'b1; w_addr[2] = 5'd9; w_data[2] = 32'hA5;
    r_en[1] = 1'b1; r_addr[1] = 5'd9;
    cycle();
`ifdef RF_BYPASS_EN
    bp_exp = 32'hA5;
`else
    bp_exp = 32'h1;
`endif
    check("same-edge x9", r_data[1], bp_exp);
    idle();
    r_en[1] = 1'b1; r_addr[1] = 5'd9;
    cycle();
    check("after x9", r_data[1], 32'hA5);

    // Randomised traffic with occasional clears.
    for (int n = 0; n < 400; n++) begin
      clr_req = ($urandom_range(0, 39) == 0);
      w_en    = NW'($urandom);
      r_en    = NRD'($urandom);
      for (int w = 0; w < NW; w++) begin
        w_addr[w] = ($urandom_range(0, 1) == 0) ? AL'($urandom_range(0, 3)) : AL'($urandom);
        w_data[w] = $urandom;
      end
      for (int r = 0; r < NRD; r++) begin
        r_addr[r] = ($urandom_range(0, 1) == 0) ? AL'($urandom_range(0, 3)) : AL'($urandom);
      end
      cycle();
    end
    idle();
    for (int k = 0; k < NCH + 2 && clr_left != 0; k++) cycle();
    check("settle rdy", 32'(rf_rdy), 32'd1);

    // Fill, then clear in READY with a concurrent read and write.
    idle();
    w_en = 4'b1111;
    for (int w = 0; w < NW; w++) begin
      w_addr[w] = AL'(10 + w);
      w_data[w] = 32'hA000_0000 + 32'(w);
    end
    cycle();
    idle();
    clr_req = 1'b1;
    w_en[0] = 1'b1; w_addr[0] = 5'd14; w_data[0] = 32'h77;
    r_en[0] = 1'b1; r_addr[0] = 5'd10;
    cycle();
    check("clr edge rdy", 32'(rf_rdy), 32'd0);
    check("clr edge r_val", 32'(r_val[0]), 32'd1);
    check("clr edge r_data", r_data[0], 32'hA000_0000);
    clr_req = 1'b0;
    for (int e = 1; e <= NCH; e++) begin
      w_data[0] = 32'hBAD0 + 32'(e);
      cycle();
      check($sformatf("clr rdy edge %0d", e), 32'(rf_rdy), 32'(e == NCH));
    end
    read_all_zero("post-clr");

    // Second clr_req on clear edge 4 restarts the sequence.
    idle();
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    repeat (3) cycle();
    clr_req = 1'b1;
    cycle();
    check("restart rdy", 32'(rf_rdy), 32'd0);
    clr_req = 1'b0;
    for (int e = 1; e <= NCH; e++) begin
      cycle();
      check($sformatf("restart rdy edge %0d", e), 32'(rf_rdy), 32'(e == NCH));
    end

    // Asynchronous reset drops r_val without waiting for an edge.
    idle();
    r_en[0] = 1'b1; r_addr[0] = 5'd3;
    cycle();
    check("pre-rst r_val", 32'(r_val[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async rst r_val", 32'(r_val), 32'd0);
    check("async rst rdy", 32'(rf_rdy), 32'd0);
    model_reset();
    idle();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) cycle();
    #2 rst = 1'b1;
    #1;
    check("mid-clear rst rdy", 32'(rf_rdy), 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int e = 1; e <= NCH; e++) begin
      cycle();
      check($sformatf("rst restart rdy edge %0d", e), 32'(rf_rdy), 32'(e == NCH));
    end
    read_all_zero("post-rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-ported architectural register file; successor to the fixed retire-port regfile.
- Sits between ROB retirement (write side) and issue (read side).
- Adds configurable port counts and sizes, a registered read with valid, and youngest-wins write-conflict resolution.
- Adds a multi-cycle clear sequencer with a ready handshake, plus optional write-to-read bypass.

Parameters:
- NUM_REGS, 32, number of architectural registers; power of 2, at least 2.
- DATA_LEN, 32, register width in bits.
- NUM_W_PORTS, 4, retire write ports.
- NUM_R_PORTS, 6, read ports (ISSUE_WIDTH x NUM_SRCS).
- CLR_PER_CYCLE, 4, registers cleared per cycle by the sequencer; must divide NUM_REGS.
- REG_ADDR_LEN, $clog2(NUM_REGS), derived; not overridable.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr_req  in  1  request a full register clear (pulse).
- rf_rdy  out  1  file initialised and accepting reads and writes.
- w_en  in  NUM_W_PORTS  per-port write enable; port index = retire age, higher index is younger.
- w_addr  in  NUM_W_PORTS x REG_ADDR_LEN  write addresses.
- w_data  in  NUM_W_PORTS x DATA_LEN  write data.
- r_en  in  NUM_R_PORTS  read enables.
- r_addr  in  NUM_R_PORTS x REG_ADDR_LEN  read addresses.
- r_val  out  NUM_R_PORTS  read data valid, one cycle after the accepted r_en.
- r_data  out  NUM_R_PORTS x DATA_LEN  registered read data.

Behaviour:
- Reset (asynchronous): state=CLEARING, clr_ptr=0, rf_rdy=0, r_val=0, r_data=0. The storage array itself is not reset.
- FSM states: CLEARING and READY.
- CLEARING, each edge:
  - Zero registers clr_ptr .. clr_ptr+CLR_PER_CYCLE-1, then clr_ptr += CLR_PER_CYCLE.
  - On the edge that clears the final chunk: go to READY and set rf_rdy=1 (registered).
  - Clear takes NUM_REGS/CLR_PER_CYCLE edges; default is 8. rf_rdy is high after the 8th edge following reset release.
- READY:
  - clr_req=1 at an edge: go to CLEARING, clr_ptr=0, rf_rdy=0. No register is cleared on that edge, so the sequence takes 1+8 edges.
- clr_req=1 while CLEARING: restart with clr_ptr=0; rf_rdy stays 0.
- Writes:
  - Commit only in READY, and only when w_en[w]=1 and w_addr[w]!=0.
  - Writes are dropped silently in CLEARING, including on the READY-to-CLEARING edge.
- Write conflict: when several enabled ports share an address, only the highest-index port commits.
- Register 0 always reads 0, regardless of writes.
- Reads:
  - Accepted when r_en[r]=1 and the FSM is in READY.
  - Next cycle: r_val[r]=1 and r_data[r]=register[r_addr[r]] as held before the edge (no bypass in the base build).
  - Not accepted: r_val[r]=0 and r_data[r]=0.
- Simultaneous clr_req and reads/writes in READY: reads still complete with pre-clear data; writes are dropped.
- Reset mid-clear: restart from clr_ptr=0.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: a read accepted on the same edge as a qualifying write to the same nonzero address returns the committing (youngest) write's data.
- Undefined: the read returns the old value, and software or RTL above must re-read.
- Port list is identical in both builds.

Decomposition:
- Shared package rf_pkg:
  - Typedefs rf_addr_t and rf_data_t.
  - Enum rf_state_e {RF_CLEARING, RF_READY}.
  - Default constants for port counts.
- One sub-module: rf_wr_arbiter, a combinational youngest-wins conflict qualifier producing per-port commit enables. It is reused by the bypass select.

Test Plan:
- Reset release -> rf_rdy=0 for edges 1-7, =1 after edge 8. Reads of all 32 registers -> 0 with r_val=1.
- Write x5=0xDEADBEEF on port 0 -> read r_addr=5 next cycle -> r_data=0xDEADBEEF one cycle after r_en.
- Same edge: ports 1 and 3 write x7 = 0x11 and 0x33 -> subsequent read returns 0x33. Write x0=0xFFFF_FFFF -> read returns 0.
- Same-edge write x9=0xA5 and read x9 (prior value 0x1) -> 0xA5 with RF_BYPASS_EN, 0x1 without.
- clr_req in READY after filling registers -> rf_rdy low for 9 edges, writes dropped, then all registers read 0.
- Second clr_req at clear edge 4 -> clr_ptr restarts at 0, rf_rdy rises 8 edges later. Asynchronous rst mid-clear -> r_val=0 immediately.
